ddr2_fifo_responder: RTL and testbench
======================================

Name: ddr2_fifo_responder

Overview:
Synthesizable DDR2-side responder for the cache's memory command interface: address/cmd FIFO, write-data FIFO and read-data FIFO, backed by a block-RAM memory array.
It accepts 256-bit line writes and reads issued as two 128-bit beats, applies active-low byte masks, and returns read lines in two beats.
It stands in for the DDR2 controller in block-level benches and FPGA bring-up without external memory, so any cache FSM can run against it unmodified.

Parameters:
LINES_LOG2, 10, log2 of number of 256-bit lines stored (memory = 2*2^LINES_LOG2 x 128 bits)
READ_LATENCY, 4, wait cycles inserted before a read's first beat is fetched (0 allowed)
AF_DEPTH, 4, address/cmd FIFO entries (power of two)
WDF_DEPTH, 8, write-data FIFO entries (power of two, >=2)
RDF_DEPTH, 4, read-data FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
af_cmd_din  in  3  command: 3'b000 write, 3'b001 read
af_addr_din  in  31  line address; bits [1:0] zero; line index = af_addr_din[LINES_LOG2+1:2]
af_wr_en  in  1  push cmd/addr
af_full  out  1  cmd FIFO full
wdf_din  in  128  write beat data
wdf_mask_din  in  16  byte mask, active-low (1 = keep old byte); bit i covers bits [8i+7:8i]
wdf_wr_en  in  1  push write beat
wdf_full  out  1  write FIFO full
rdf_rd_en  in  1  pop read beat
rdf_valid  out  1  read FIFO non-empty; rdf_dout valid
rdf_dout  out  128  head of read FIFO
busy  out  1  engine not in IDLE or any FIFO non-empty
err  out  1  sticky: push to full FIFO, unknown cmd, or rdf_rd_en while empty

Behaviour:
- Reset (rst low, async): all FIFOs empty, FSM IDLE, wait counter 0. af_full=0, wdf_full=0, rdf_valid=0, rdf_dout=0, busy=0, err=0. Memory array not cleared. Reset mid-operation drops the in-flight command and all queued beats.
- FIFOs: pushes are registered; an entry is visible at the head the cycle after its push. Full = count==DEPTH. Push while full: data dropped, err set. rdf pops when rdf_rd_en && rdf_valid. Simultaneous push and pop on the same FIFO is legal in every count state, including full.
- Beat order: beat 0 = line bits [255:128], beat 1 = bits [127:0]; memory word address = {line, ~beat}.
- Commands execute strictly in order, so a read issued after a write returns the written data.
- FSM:
  - IDLE: when af non-empty, the head selects the next state.
    - Write head and wdf non-empty -> WR0.
    - Read head and rdf free entries >=2 -> WAIT, or RD0 if READ_LATENCY=0.
    - Unknown cmd -> pop af, set err, stay IDLE.
  - WR0: masked write of wdf head as beat 0; pop wdf -> WR1.
  - WR1: wait until wdf non-empty; masked write beat 1; pop wdf and af -> IDLE.
  - WAIT: count READ_LATENCY cycles -> RD0.
  - RD0: issue synchronous memory read of beat 0 -> RD1.
  - RD1: push beat 0 into rdf; issue read of beat 1 -> RD2.
  - RD2: push beat 1; pop af -> IDLE.
- The free-space check happens before RD0, so a read burst never stalls mid-burst.
- Read latency: with af_wr_en in cycle t, engine idle and rdf empty, rdf_valid first rises in cycle t+READ_LATENCY+4. Beat 1 is at the head the cycle after beat 0 is popped.
- Write latency: af and beat 0 pushed in cycle t, beat 1 in t+1 -> memory updated by end of cycle t+3; an immediate read sees the new data.
- Address bits above LINES_LOG2+1 are ignored: addresses wrap modulo the array size.
- Masks: all-ones mask = no-op write (still consumes the beat); all-zero mask = full beat write.

Decomposition:
- Shared package/header holds: command encodings (CMD_WRITE=3'b000, CMD_READ=3'b001), FSM state encodings, beat width 128, mask width 16, and the line-index field macro.
- One natural sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count), instantiated three times: af 34 bits, wdf 144 bits, rdf 128 bits.
- Memory array and FSM stay in the top level.

Test Plan:
1. Full write then read, line 0x10: beat0=0xAAAA..., beat1=0x5555..., masks 0x0000; then read 0x10 -> rdf_dout beat0=0xAAAA..., beat1=0x5555..., rdf_valid first at t+8 (READ_LATENCY=4).
2. Partial write 0x10: beat0 mask 16'hFFF0, data 0x...DEADBEEF (low bytes), beat1 mask 16'hFFFF -> read returns beat0 low 32 bits 0xDEADBEEF, all other bytes unchanged from test 1.
3. Back-pressure: hold rdf_rd_en=0 and issue 3 reads -> after 2 reads rdf full; third read waits in IDLE; af_full asserts after 4 queued cmds; no err; all 6 beats delivered in order once popped.
4. Write data lag: af write cmd pushed, wdf beat 1 delayed 10 cycles -> engine holds in WR1, busy=1, memory beat 1 unchanged until the push, no err.
5. Errors: push af while full, cmd 3'b010, rdf_rd_en while empty -> err=1 (sticky), unknown cmd discarded, queue order of valid cmds preserved.
6. Async reset asserted during RD1 -> outputs immediately 0; after release a new read to line 0x10 returns the stored data correctly.

Source files
------------

// File: rtl/ddr2_fifo_responder_pkg.sv
// Shared definitions for the DDR2 FIFO responder.
// Holds the command encodings, FSM state encodings, beat/mask widths and
// the helper that extracts the line-index field from a command address.
package ddr2_fifo_responder_pkg;

  localparam int BEAT_W = 128;
  localparam int MASK_W = 16;
  localparam int ADDR_W = 31;
  localparam int CMD_W  = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b000;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_WAIT,
    S_RD0,
    S_RD1,
    S_RD2
  } state_t;

  // Address bits [1:0] are always zero; the line index starts at bit 2.
  // The caller truncates the result to its own line-index width.
  function automatic logic [ADDR_W-1:0] line_field(input logic [ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/ddr2_fifo_responder_sync_fifo.sv
// Synchronous FIFO used for the command, write-data and read-data queues.
// Ports:
//   clk, rst   clock, asynchronous active-low reset (pointers/count only)
//   push, din  write an entry; accepted when not full, or when full and
//              popping in the same cycle
//   pop        remove the head entry; ignored while empty
//   dout       head entry (only meaningful while !empty)
//   full/empty/count  occupancy status
module ddr2_fifo_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ddr2_fifo_responder.sv
// DDR2-side responder model: command FIFO, write-data FIFO and read-data FIFO
// in front of a block-RAM array of 256-bit lines stored as two 128-bit words.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   af_cmd_din/af_addr_din/af_wr_en/af_full   command queue (write/read line)
//   wdf_din/wdf_mask_din/wdf_wr_en/wdf_full   write beats, active-low byte mask
//   rdf_rd_en/rdf_valid/rdf_dout              read beats returned to the host
//   busy                         engine active or any FIFO holds data
//   err                          sticky: overflow, unknown cmd, pop while empty
module ddr2_fifo_responder
  import ddr2_fifo_responder_pkg::*;
#(
  parameter int LINES_LOG2   = 10,
  parameter int READ_LATENCY = 4,
  parameter int AF_DEPTH     = 4,
  parameter int WDF_DEPTH    = 8,
  parameter int RDF_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  af_cmd_din,
  input  logic [ADDR_W-1:0] af_addr_din,
  input  logic              af_wr_en,
  output logic              af_full,
  input  logic [BEAT_W-1:0] wdf_din,
  input  logic [MASK_W-1:0] wdf_mask_din,
  input  logic              wdf_wr_en,
  output logic              wdf_full,
  input  logic              rdf_rd_en,
  output logic              rdf_valid,
  output logic [BEAT_W-1:0] rdf_dout,
  output logic              busy,
  output logic              err
);

  localparam int WADDR_W = LINES_LOG2 + 1;
  localparam int WORDS   = 2 ** WADDR_W;
  localparam int AF_W    = CMD_W + ADDR_W;
  localparam int WDF_W   = MASK_W + BEAT_W;
  localparam int WCNT_W  = $clog2(READ_LATENCY + 2);
  localparam int AFC_W   = $clog2(AF_DEPTH + 1);
  localparam int WDC_W   = $clog2(WDF_DEPTH + 1);
  localparam int RDC_W   = $clog2(RDF_DEPTH + 1);

  state_t state, state_n;

  logic [AF_W-1:0]       af_head;
  logic                  af_empty;
  logic [AFC_W-1:0]      af_count;
  logic                  af_pop;
  logic [WDF_W-1:0]      wdf_head;
  logic                  wdf_empty;
  logic [WDC_W-1:0]      wdf_count;
  logic                  wdf_pop;
  logic [BEAT_W-1:0]     rdf_head;
  logic                  rdf_full;
  logic                  rdf_empty;
  logic [RDC_W-1:0]      rdf_count;
  logic                  rdf_push;
  logic                  rdf_pop;

  logic [CMD_W-1:0]      head_cmd;
  logic [LINES_LOG2-1:0] head_line;
  logic [MASK_W-1:0]     wr_mask;
  logic [BEAT_W-1:0]     wr_data;
  logic                  beat;
  logic [WADDR_W-1:0]    mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic                  bad_cmd;
  logic [WCNT_W-1:0]     wcnt;
  logic                  wait_done;
  logic                  err_set;

  logic [BEAT_W-1:0]     mem_q [WORDS];
  logic [BEAT_W-1:0]     rd_beat_p1;

  ddr2_fifo_responder_sync_fifo #(.WIDTH(AF_W), .DEPTH(AF_DEPTH)) u_af (
    .clk(clk), .rst(rst), .push(af_wr_en), .pop(af_pop),
    .din({af_cmd_din, af_addr_din}), .dout(af_head),
    .full(af_full), .empty(af_empty), .count(af_count)
  );

  ddr2_fifo_responder_sync_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk(clk), .rst(rst), .push(wdf_wr_en), .pop(wdf_pop),
    .din({wdf_mask_din, wdf_din}), .dout(wdf_head),
    .full(wdf_full), .empty(wdf_empty), .count(wdf_count)
  );

  ddr2_fifo_responder_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(RDF_DEPTH)) u_rdf (
    .clk(clk), .rst(rst), .push(rdf_push), .pop(rdf_pop),
    .din(rd_beat_p1), .dout(rdf_head),
    .full(rdf_full), .empty(rdf_empty), .count(rdf_count)
  );

  assign head_cmd  = af_head[AF_W-1 -: CMD_W];
  // Upper address bits are dropped here, so addresses wrap modulo the array.
  assign head_line = LINES_LOG2'(line_field(af_head[ADDR_W-1:0]));
  assign wr_mask   = wdf_head[WDF_W-1 -: MASK_W];
  assign wr_data   = wdf_head[BEAT_W-1:0];
  // Beat 0 carries line bits [255:128], stored at the odd word.
  assign mem_addr  = {head_line, ~beat};
  assign wait_done = (wcnt == WCNT_W'(READ_LATENCY - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= (state == S_WAIT && !wait_done) ? wcnt + 1'b1 : '0;
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    af_pop   = 1'b0;
    wdf_pop  = 1'b0;
    rdf_push = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    beat     = 1'b0;
    bad_cmd  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!af_empty) begin
          if (head_cmd == CMD_WRITE) begin
            if (!wdf_empty) state_n = S_WR0;
          end else if (head_cmd == CMD_READ) begin
            // Reserve room for both beats up front so a burst never stalls.
            if (rdf_count <= RDC_W'(RDF_DEPTH - 2))
              state_n = (READ_LATENCY == 0) ? S_RD0 : S_WAIT;
          end else begin
            af_pop  = 1'b1;
            bad_cmd = 1'b1;
          end
        end
      end
      S_WR0: begin
        mem_we  = 1'b1;
        wdf_pop = 1'b1;
        state_n = S_WR1;
      end
      S_WR1: begin
        beat = 1'b1;
        if (!wdf_empty) begin
          mem_we  = 1'b1;
          wdf_pop = 1'b1;
          af_pop  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_done) state_n = S_RD0;
      end
      S_RD0: begin
        mem_re  = 1'b1;
        state_n = S_RD1;
      end
      S_RD1: begin
        rdf_push = 1'b1;
        mem_re   = 1'b1;
        beat     = 1'b1;
        state_n  = S_RD2;
      end
      S_RD2: begin
        rdf_push = 1'b1;
        af_pop   = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Memory array: not reset; masked byte writes, registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!wr_mask[i]) mem_q[mem_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (mem_re) rd_beat_p1 <= mem_q[mem_addr];
  end

  assign rdf_pop   = rdf_rd_en && !rdf_empty;
  assign err_set   = bad_cmd
                   || (af_wr_en && af_full && !af_pop)
                   || (wdf_wr_en && wdf_full && !wdf_pop)
                   || (rdf_push && rdf_full && !rdf_pop)
                   || (rdf_rd_en && rdf_empty);

  assign rdf_valid = !rdf_empty;
  assign rdf_dout  = rdf_valid ? rdf_head : '0;
  assign busy      = (state != S_IDLE) || (af_count != '0) || (wdf_count != '0)
                   || (rdf_count != '0);

endmodule

// File: tb/tb_ddr2_fifo_responder.sv
module tb_ddr2_fifo_responder;
  import ddr2_fifo_responder_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   af_cmd_din = '0;
  logic [30:0]  af_addr_din = '0;
  logic         af_wr_en = 1'b0;
  logic         af_full;
  logic [127:0] wdf_din = '0;
  logic [15:0]  wdf_mask_din = '0;
  logic         wdf_wr_en = 1'b0;
  logic         wdf_full;
  logic         rdf_rd_en = 1'b0;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         busy;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] A_PAT = {16{8'hAA}};
  localparam logic [127:0] F_PAT = {16{8'h55}};

  ddr2_fifo_responder dut (
    .clk(clk), .rst(rst),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .af_full(af_full),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .wdf_full(wdf_full),
    .rdf_rd_en(rdf_rd_en), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d failures)", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] la(input int line);
    return 31'(line) << 2;
  endfunction

  function automatic logic [127:0] pat(input int line, input int b);
    logic [15:0] c;
    c = {(b != 0) ? 8'h1B : 8'h0B, 8'(line)};
    return {8{c}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_af(input logic [2:0] cmd, input logic [30:0] addr);
    af_cmd_din = cmd; af_addr_din = addr; af_wr_en = 1'b1;
    tick();
    af_wr_en = 1'b0;
  endtask

  task automatic push_wd(input logic [127:0] d, input logic [15:0] m);
    wdf_din = d; wdf_mask_din = m; wdf_wr_en = 1'b1;
    tick();
    wdf_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic write_line(input int line, input logic [127:0] b0, input logic [127:0] b1,
                            input logic [15:0] m0, input logic [15:0] m1);
    af_cmd_din = CMD_WRITE; af_addr_din = la(line); af_wr_en = 1'b1;
    wdf_din = b0; wdf_mask_din = m0; wdf_wr_en = 1'b1;
    tick();
    af_wr_en = 1'b0;
    wdf_din = b1; wdf_mask_din = m1;
    tick();
    wdf_wr_en = 1'b0;
    wait_idle("wr_idle");
  endtask

  task automatic pop_expect(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!rdf_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, rdf_valid, 1'b1);
    chk(tag, rdf_dout, exp);
    if (rdf_valid) begin
      rdf_rd_en = 1'b1;
      tick();
      rdf_rd_en = 1'b0;
    end
  endtask

  task automatic read_line(input string tag, input logic [30:0] addr,
                           input logic [127:0] e0, input logic [127:0] e1);
    push_af(CMD_READ, addr);
    pop_expect({tag, "_b0"}, e0);
    chk({tag, "_b1_next"}, rdf_valid, 1'b1);
    pop_expect({tag, "_b1"}, e1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_rdf_valid", rdf_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  logic [127:0] l10_b0;

  initial begin
    // Reset state
    #2;
    chk("rst_af_full", af_full, 1'b0);
    chk("rst_wdf_full", wdf_full, 1'b0);
    chk("rst_rdf_valid", rdf_valid, 1'b0);
    chk("rst_rdf_dout", rdf_dout, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // 1: full write then read of line 0x10, with read latency
    write_line(16'h10, A_PAT, F_PAT, 16'h0000, 16'h0000);
    begin
      int n = 0;
      push_af(CMD_READ, la(16'h10));
      while (!rdf_valid && n < 30) begin
        tick();
        n++;
      end
      chk("t1_latency", 128'(n), 128'(7));
      pop_expect("t1_b0", A_PAT);
      chk("t1_b1_next", rdf_valid, 1'b1);
      pop_expect("t1_b1", F_PAT);
    end

    // 2: partial write with byte masks
    write_line(16'h10, {{12{8'h11}}, 32'hDEADBEEF}, {16{8'h77}}, 16'hFFF0, 16'hFFFF);
    l10_b0 = {{12{8'hAA}}, 32'hDEADBEEF};
    read_line("t2", la(16'h10), l10_b0, F_PAT);
    chk("t2_err", err, 1'b0);

    // 3: back-pressure with the read FIFO left unpopped
    for (int l = 16'h20; l < 16'h23; l++) write_line(l, pat(l, 0), pat(l, 1), 16'h0, 16'h0);
    push_af(CMD_READ, la(16'h20));
    push_af(CMD_READ, la(16'h21));
    push_af(CMD_READ, la(16'h22));
    push_af(CMD_READ, la(16'h10));
    chk("t3_af_full", af_full, 1'b1);
    repeat (40) tick();
    chk("t3_rdf_valid", rdf_valid, 1'b1);
    chk("t3_af_not_full", af_full, 1'b0);
    chk("t3_busy", busy, 1'b1);
    chk("t3_err", err, 1'b0);
    for (int l = 16'h20; l < 16'h23; l++) begin
      pop_expect("t3_b0", pat(l, 0));
      pop_expect("t3_b1", pat(l, 1));
    end
    pop_expect("t3_l10_b0", l10_b0);
    pop_expect("t3_l10_b1", F_PAT);
    wait_idle("t3_idle");
    chk("t3_err_end", err, 1'b0);

    // 4: write beat 1 arrives late
    af_cmd_din = CMD_WRITE; af_addr_din = la(16'h11); af_wr_en = 1'b1;
    wdf_din = pat(16'h11, 0); wdf_mask_din = 16'h0; wdf_wr_en = 1'b1;
    tick();
    af_wr_en = 1'b0; wdf_wr_en = 1'b0;
    repeat (10) tick();
    chk("t4_busy_hold", busy, 1'b1);
    chk("t4_err", err, 1'b0);
    push_wd(pat(16'h11, 1), 16'h0);
    wait_idle("t4_idle");
    read_line("t4", la(16'h11), pat(16'h11, 0), pat(16'h11, 1));
    chk("t4_err_end", err, 1'b0);

    // 5a: pop while empty sets a sticky error
    rdf_rd_en = 1'b1;
    tick();
    rdf_rd_en = 1'b0;
    chk("t5a_err", err, 1'b1);
    repeat (3) tick();
    chk("t5a_sticky", err, 1'b1);
    rst = 1'b0;
    #2;
    chk("t5a_rst_err", err, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // 5b: unknown command discarded, surrounding reads keep their order
    push_af(CMD_READ, la(16'h10));
    push_af(3'b010, la(16'h20));
    push_af(CMD_READ, la(16'h11));
    pop_expect("t5b_l10_b0", l10_b0);
    pop_expect("t5b_l10_b1", F_PAT);
    pop_expect("t5b_l11_b0", pat(16'h11, 0));
    pop_expect("t5b_l11_b1", pat(16'h11, 1));
    wait_idle("t5b_idle");
    chk("t5b_err", err, 1'b1);
    do_reset_quiet();

    // 5c: command FIFO overflow drops the extra command only
    push_af(CMD_WRITE, la(16'h12));
    push_af(CMD_READ, la(16'h12));
    push_af(CMD_READ, la(16'h10));
    push_af(CMD_READ, la(16'h11));
    chk("t5c_af_full", af_full, 1'b1);
    chk("t5c_err_before", err, 1'b0);
    push_af(CMD_READ, la(16'h20));
    chk("t5c_err_ovf", err, 1'b1);
    push_wd(pat(16'h12, 0), 16'h0);
    push_wd(pat(16'h12, 1), 16'h0);
    pop_expect("t5c_l12_b0", pat(16'h12, 0));
    pop_expect("t5c_l12_b1", pat(16'h12, 1));
    pop_expect("t5c_l10_b0", l10_b0);
    pop_expect("t5c_l10_b1", F_PAT);
    pop_expect("t5c_l11_b0", pat(16'h11, 0));
    pop_expect("t5c_l11_b1", pat(16'h11, 1));
    wait_idle("t5c_idle");
    chk("t5c_no_extra", rdf_valid, 1'b0);
    do_reset_quiet();

    // 5d: write-data FIFO fills at eight beats, ninth push overflows
    for (int i = 0; i < 8; i++) push_wd(pat(i, 0), 16'h0);
    chk("t5d_wdf_full", wdf_full, 1'b1);
    chk("t5d_err_before", err, 1'b0);
    push_wd(pat(9, 0), 16'h0);
    chk("t5d_err_ovf", err, 1'b1);
    do_reset_quiet();
    chk("t5d_wdf_cleared", wdf_full, 1'b0);

    // 6: asynchronous reset while the engine is in RD1
    push_af(CMD_READ, la(16'h10));
    repeat (6) tick();
    chk("t6_busy_pre", busy, 1'b1);
    do_reset();
    chk("t6_dout", rdf_dout, 128'h0);
    chk("t6_busy_post", busy, 1'b0);
    // Address above the array size wraps back onto line 0x10
    read_line("t6", la((1 << 10) | 16'h10), l10_b0, F_PAT);
    chk("t6_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic do_reset_quiet();
    rst = 1'b0;
    #2;
    tick();
    rst = 1'b1;
    tick();
  endtask

endmodule
